// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared state encoding and master indices for wb_arbiter
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin Wishbone-style arbiter with transaction lock and timeout
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = `ADDR_SIZE,
    parameter int DATA_W  = `WORD_SIZE,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] M0_addr,
    input  logic              M0_cs,
    input  logic              M0_we,
    input  logic [DATA_W-1:0] M0_wdata,
    output logic [DATA_W-1:0] M0_rdata,
    output logic              M0_ack,
    output logic              M0_err,
    input  logic [ADDR_W-1:0] M1_addr,
    input  logic              M1_cs,
    input  logic              M1_we,
    input  logic [DATA_W-1:0] M1_wdata,
    output logic [DATA_W-1:0] M1_rdata,
    output logic              M1_ack,
    output logic              M1_err,
    output logic [ADDR_W-1:0] S_addr,
    output logic              S_cs,
    output logic              S_we,
    output logic [DATA_W-1:0] S_wdata,
    input  logic [DATA_W-1:0] S_rdata,
    input  logic              S_ack,
    output logic [1:0]        Grant
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_e    state, next_state;
    logic          last, next_last;
    logic [TW-1:0] tcnt, next_tcnt;
    logic          own;
    logic          timeout;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            last  <= M1;
            tcnt  <= '0;
        end else begin
            state <= next_state;
            last  <= next_last;
            tcnt  <= next_tcnt;
        end
    end

    always_comb begin
        next_state = state;
        next_last  = last;
        next_tcnt  = tcnt;
        own        = M0;
        timeout    = 1'b0;
        S_addr     = '0;
        S_cs       = 1'b0;
        S_we       = 1'b0;
        S_wdata    = '0;
        M0_rdata   = '0;
        M0_ack     = 1'b0;
        M0_err     = 1'b0;
        M1_rdata   = '0;
        M1_ack     = 1'b0;
        M1_err     = 1'b0;
        Grant      = 2'b00;

        unique case (state)
            IDLE: begin
                next_tcnt = '0;
                // On a tie the master that was not served last wins.
                if (M0_cs && (!M1_cs || last == M1))
                    next_state = BUSY0;
                else if (M1_cs)
                    next_state = BUSY1;
            end
            BUSY0, BUSY1: begin
                own     = (state == BUSY1) ? M1 : M0;
                S_addr  = own ? M1_addr  : M0_addr;
                S_cs    = own ? M1_cs    : M0_cs;
                S_we    = own ? M1_we    : M0_we;
                S_wdata = own ? M1_wdata : M0_wdata;
                Grant   = own ? 2'b10 : 2'b01;
                if (own) begin
                    M1_rdata = S_rdata;
                    M1_ack   = S_ack;
                end else begin
                    M0_rdata = S_rdata;
                    M0_ack   = S_ack;
                end
                // An ack in the final allowed cycle takes precedence over the timeout.
                timeout = !S_ack && S_cs && (tcnt == TLAST);
                M0_err  = timeout && (own == M0);
                M1_err  = timeout && (own == M1);
                if (S_ack || !S_cs || timeout) begin
                    next_state = IDLE;
                    next_last  = own;
                end else begin
                    next_tcnt = tcnt + TW'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
`timescale 1ns/1ps
module tb_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [AW-1:0] M0_addr = '0, M1_addr = '0, S_addr;
    logic          M0_cs = 1'b0, M0_we = 1'b0, M1_cs = 1'b0, M1_we = 1'b0;
    logic [DW-1:0] M0_wdata = '0, M1_wdata = '0, S_wdata, S_rdata = '0;
    logic [DW-1:0] M0_rdata, M1_rdata;
    logic          M0_ack, M0_err, M1_ack, M1_err, S_cs, S_we;
    logic          S_ack = 1'b0;
    logic [1:0]    Grant;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .M0_addr(M0_addr), .M0_cs(M0_cs), .M0_we(M0_we), .M0_wdata(M0_wdata),
        .M0_rdata(M0_rdata), .M0_ack(M0_ack), .M0_err(M0_err),
        .M1_addr(M1_addr), .M1_cs(M1_cs), .M1_we(M1_we), .M1_wdata(M1_wdata),
        .M1_rdata(M1_rdata), .M1_ack(M1_ack), .M1_err(M1_err),
        .S_addr(S_addr), .S_cs(S_cs), .S_we(S_we), .S_wdata(S_wdata),
        .S_rdata(S_rdata), .S_ack(S_ack), .Grant(Grant)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 64'(Grant), 64'd0);
        chk({tag, "_scs"}, 64'(S_cs), 64'd0);
        chk({tag, "_acks"}, 64'({M0_ack, M1_ack}), 64'd0);
        chk({tag, "_errs"}, 64'({M0_err, M1_err}), 64'd0);
        chk({tag, "_rdata"}, 64'({M0_rdata, M1_rdata}), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge Clk);
        #1;
        chk_quiet("reset");
        Rst = 1'b1;

        // test 1: M0 read, slave acks two cycles after S_cs rises
        M0_cs = 1'b1; M0_we = 1'b0; M0_addr = 32'h100;
        #1;
        chk("t1_idle_scs", 64'(S_cs), 64'd0);
        next_cyc();
        chk("t1_scs", 64'(S_cs), 64'd1);
        chk("t1_addr", 64'(S_addr), 64'h100);
        chk("t1_grant", 64'(Grant), 64'b01);
        chk("t1_ack_early", 64'(M0_ack), 64'd0);
        next_cyc();
        chk("t1_ack_wait", 64'(M0_ack), 64'd0);
        next_cyc();
        S_ack = 1'b1; S_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_ack", 64'(M0_ack), 64'd1);
        chk("t1_rdata", 64'(M0_rdata), 64'hDEADBEEF);
        chk("t1_m1_rdata", 64'(M1_rdata), 64'd0);
        next_cyc();
        S_ack = 1'b0; M0_cs = 1'b0;
        #1;
        chk_quiet("t1_after");

        // test 2: simultaneous requests after reset alternate M0, M1, M0, M1
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
        M0_cs = 1'b1; M1_cs = 1'b1; S_ack = 1'b1; S_rdata = 32'h5A5A0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t2_idle%0d_grant", i), 64'(Grant), 64'd0);
            chk($sformatf("t2_idle%0d_acks", i), 64'({M0_ack, M1_ack}), 64'd0);
            next_cyc();
            chk($sformatf("t2_busy%0d_grant", i), 64'(Grant), (i % 2 == 0) ? 64'b01 : 64'b10);
            chk($sformatf("t2_busy%0d_acks", i), 64'({M0_ack, M1_ack}), (i % 2 == 0) ? 64'b10 : 64'b01);
            next_cyc();
        end
        M0_cs = 1'b0; M1_cs = 1'b0; S_ack = 1'b0; S_rdata = '0;
        #1;
        chk_quiet("t2_after");

        // test 3: M1 write while M0 idle
        M1_cs = 1'b1; M1_we = 1'b1; M1_addr = 32'h20; M1_wdata = 32'h12345678;
        #1;
        chk("t3_idle_we", 64'(S_we), 64'd0);
        next_cyc();
        chk("t3_grant", 64'(Grant), 64'b10);
        chk("t3_we", 64'(S_we), 64'd1);
        chk("t3_addr", 64'(S_addr), 64'h20);
        chk("t3_wdata", 64'(S_wdata), 64'h12345678);
        chk("t3_m0_ack", 64'(M0_ack), 64'd0);
        next_cyc();
        S_ack = 1'b1;
        #1;
        chk("t3_m1_ack", 64'(M1_ack), 64'd1);
        chk("t3_m0_ack2", 64'(M0_ack), 64'd0);
        next_cyc();
        S_ack = 1'b0; M1_cs = 1'b0; M1_we = 1'b0;
        #1;
        chk_quiet("t3_after");

        // test 4: M0 times out with M1 pending; M0 wins the tie since M1 was served last
        M0_cs = 1'b1; M0_addr = 32'h44; M1_cs = 1'b1; M1_addr = 32'h88;
        next_cyc();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t4_c%0d_grant", i), 64'(Grant), 64'b01);
            chk($sformatf("t4_c%0d_scs", i), 64'(S_cs), 64'd1);
            chk($sformatf("t4_c%0d_err", i), 64'({M0_err, M1_err}), (i == 4) ? 64'b10 : 64'b00);
            next_cyc();
        end
        M0_cs = 1'b0;
        #1;
        chk("t4_idle_scs", 64'(S_cs), 64'd0);
        chk("t4_idle_err", 64'(M0_err), 64'd0);
        next_cyc();
        chk("t4_m1_grant", 64'(Grant), 64'b10);
        chk("t4_m1_addr", 64'(S_addr), 64'h88);
        S_ack = 1'b1;
        #1;
        chk("t4_m1_ack", 64'(M1_ack), 64'd1);
        next_cyc();
        S_ack = 1'b0; M1_cs = 1'b0;
        #1;
        chk_quiet("t4_after");

        // test 5: ack in the fourth BUSY cycle beats the timeout
        M0_cs = 1'b1;
        next_cyc();
        next_cyc();
        next_cyc();
        next_cyc();
        S_ack = 1'b1; S_rdata = 32'hCAFE0005;
        #1;
        chk("t5_ack", 64'(M0_ack), 64'd1);
        chk("t5_err", 64'(M0_err), 64'd0);
        chk("t5_rdata", 64'(M0_rdata), 64'hCAFE0005);
        next_cyc();
        S_ack = 1'b0; S_rdata = '0; M0_cs = 1'b0;
        #1;
        chk_quiet("t5_after");

        // test 6: async reset in the middle of a BUSY1 transfer
        M1_cs = 1'b1;
        next_cyc();
        chk("t6_grant", 64'(Grant), 64'b10);
        S_ack = 1'b1; S_rdata = 32'hAAAA5555;
        #1;
        Rst = 1'b0;
        #1;
        chk_quiet("t6_reset");
        S_ack = 1'b0; S_rdata = '0; M0_cs = 1'b1;
        next_cyc();
        Rst = 1'b1;
        #1;
        chk("t6_idle_grant", 64'(Grant), 64'd0);
        next_cyc();
        chk("t6_tie_grant", 64'(Grant), 64'b01);
        M0_cs = 1'b0; M1_cs = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave arbiter for the single-word Wishbone-style bus (addr/cs/we/wdata/rdata/ack) driven by the core's control unit.
- Shares the memory port between M0 (core) and M1 (loader/debug/DMA requester).
- Round-robin grant, transaction lock until ack, and a bus timeout that reports an error to the stalled master.
- Sits between the requesters and the memory/peripheral slave.

Parameters:
- ADDR_W, `ADDR_SIZE, address width.
- DATA_W, `WORD_SIZE, data width.
- TIMEOUT, 255, max BUSY cycles without slave ack before error (legal range 2..65535).

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous reset, active-low
- M0_addr  in  ADDR_W  master 0 address
- M0_cs  in  1  master 0 request; held until M0_ack or M0_err
- M0_we  in  1  master 0 write enable
- M0_wdata  in  DATA_W  master 0 write data
- M0_rdata  out  DATA_W  master 0 read data
- M0_ack  out  1  master 0 transfer done
- M0_err  out  1  master 0 timeout, 1-cycle pulse
- M1_addr, M1_cs, M1_we, M1_wdata, M1_rdata, M1_ack, M1_err: same as M0, for master 1
- S_addr  out  ADDR_W  slave address
- S_cs  out  1  slave select
- S_we  out  1  slave write enable
- S_wdata  out  DATA_W  slave write data
- S_rdata  in  DATA_W  slave read data
- S_ack  in  1  slave done
- Grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Registers: state {IDLE, BUSY0, BUSY1}, last (1 bit, last served master), tcnt ($clog2(TIMEOUT+1) bits).
- Reset (Rst=0, async): state=IDLE, last=1 (M0 wins the first tie), tcnt=0.
- All outputs 0 during reset and in IDLE: S_*, Mx_ack, Mx_rdata, Mx_err, Grant.
- IDLE decision:
  - Only M0_cs -> BUSY0.
  - Only M1_cs -> BUSY1.
  - Both -> BUSY(~last).
  - Neither -> stay IDLE.
  - tcnt cleared on every entry to BUSY.
- Latency: request sampled in cycle N (IDLE); S_cs=1 in cycle N+1.
- BUSYx:
  - S_addr/S_cs/S_we/S_wdata combinationally follow Mx_*; Grant[x]=1.
  - Mx_rdata=S_rdata and Mx_ack=S_ack combinationally.
  - Non-granted master sees ack=0, rdata=0, err=0.
- BUSYx exits:
  - S_ack=1 -> IDLE, last=x.
  - Mx_cs=0 without ack (abort) -> IDLE, last=x, no ack, no err.
  - No ack and tcnt==TIMEOUT-1 -> Mx_err=1 this cycle, S_cs still 1 this cycle, -> IDLE, last=x.
  - Otherwise tcnt++.
- Simultaneous S_ack and timeout in the same cycle: ack wins, no err.
- S_ack while IDLE: ignored, nothing forwarded.
- Back-to-back: at least one IDLE cycle after every transaction (1-cycle arbitration bubble).
  - The same master re-requesting while the other is also requesting loses the tie (fairness).
- Async reset mid-BUSY: S_cs drops immediately. Master retries after reset release; no ack or err is generated.
- No combinational path from Mx_cs to Grant. S_cs is combinational from Mx_cs only when state==BUSYx.

Decomposition:
- ADDR_SIZE/WORD_SIZE come from the shared defines header.
- Shared package holds:
  - arb_state_e enum (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2)
  - master-index constants M0=1'b0, M1=1'b1
- Everything else is a single module; no sub-module. The bus mux is inline.

Test Plan:
- Reset then M0_cs=1, M0_we=0, M0_addr=0x100, slave acks with 0xDEADBEEF 2 cycles after S_cs -> S_cs rises 1 cycle after M0_cs; M0_ack=1 with M0_rdata=0xDEADBEEF; Grant 01->00.
- M0_cs and M1_cs both raised in the same cycle after reset, slave acks in 1 cycle, both held -> order M0, M1, M0, M1, each separated by one IDLE cycle.
- M1 write M1_addr=0x20, M1_wdata=0x12345678 while M0 idle -> S_we=1, S_addr=0x20, S_wdata=0x12345678; M0_ack stays 0 throughout.
- TIMEOUT=4, M0 request, slave never acks -> M0_err=1 in the 4th BUSY cycle, S_cs=0 next cycle; a pending M1 request is then granted.
- TIMEOUT=4, slave acks exactly in the 4th BUSY cycle -> M0_ack=1, M0_err=0.
- Rst pulsed low mid-BUSY1 -> all outputs 0 asynchronously; after release, M0/M1 tie grants M0.
